rotate_fb_bridge: RTL
=====================

Name: rotate_fb_bridge

Overview:
- Memory-side stage directly downstream of the video pipeline's rotation interfaces.
- Services two burst clients on one clock: vidin (16-word write bursts of incoming pixels) and vidout (8-word read bursts of rotated pixels).
- Arbitrates both clients onto a single word-handshaked SDRAM-controller port.
- Composes framebuffer addresses from frame/x/y.

Parameters:
ADDR_W, 24, memory word-address width
BASE_ADDR, 24'h000000, framebuffer base word address
WR_LEN, 16, words per vidin burst
RD_LEN, 8, words per vidout burst

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
vidin_req  in  1  write burst pending
vidin_frame  in  1  double-buffer select for write
vidin_x  in  10  burst x position
vidin_y  in  10  row y position
vidin_d  in  16  write data; client advances on vidin_ack
vidin_ack  out  1  word consumed
vidout_req  in  1  read burst pending
vidout_frame  in  1  double-buffer select for read
vidout_x  in  10  burst x position
vidout_y  in  10  row y position
vidout_d  out  16  read data
vidout_ack  out  1  vidout_d valid
mem_req  out  1  burst active, held for whole burst
mem_we  out  1  1 = write burst
mem_addr  out  ADDR_W  first word address of burst
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid with mem_ack
mem_ack  in  1  one word transferred this cycle

Behaviour:
- Reset (synchronous, active-high): state IDLE; mem_req=0, mem_we=0, mem_addr=0, vidin_ack=0, vidout_ack=0, vidout_d=0; last_grant=write, so the first contended grant goes to read.
- Reset mid-burst: burst abandoned, mem_req=0 next cycle, counter cleared; the memory controller shares the reset.
- States:
  - IDLE: sample requests.
    - vidin_req only -> WR.
    - vidout_req only -> RD.
    - Both -> the client not in last_grant (round robin).
    - Registered on grant: mem_req=1, mem_we, mem_addr, last_grant. Grant-to-mem_req latency is 1 cycle.
  - WR: each mem_ack increments word counter. On ack number WR_LEN -> GAP, mem_req=0 next cycle.
  - RD: same, counting to RD_LEN.
  - GAP: one cycle, always -> IDLE. Lets clients update req/x/y after the final ack. Requests are never sampled in GAP.
- Address: mem_addr = BASE_ADDR + {frame, y[9:0], x[9:0]}, zero-extended to ADDR_W, modulo 2^ADDR_W.
  - Uses the client's frame/x/y latched at grant; these are stable for the burst.
  - The memory controller increments within the burst.
- Write data path:
  - mem_wdata = vidin_d (combinational).
  - vidin_ack = mem_ack & (state==WR), combinational, 0-cycle.
- Read data path:
  - vidout_ack registered: = mem_ack & (state==RD), one cycle after mem_ack.
  - vidout_d registered from mem_rdata on mem_ack in RD, else held.
  - Read-data latency is 1 cycle.
- mem_ack outside WR/RD is ignored; no client ack is produced.
- mem_ack may have arbitrary gaps; the counter only advances on ack.
- Word counter is 5 bits; it wraps to 0 on each burst completion.
- A req dropped mid-burst does not abort the burst; it completes.
- Minimum inter-burst spacing: final ack -> GAP -> IDLE -> mem_req, i.e. 3 cycles between the final ack and the next mem_req rise.

Decomposition:
- Shared package rotate_fb_pkg:
  - state encoding (IDLE, WR, RD, GAP);
  - WR_LEN/RD_LEN defaults;
  - address-compose function fb_addr(base, frame, y, x).
- Sub-module rotate_fb_arb: 2-client round-robin arbiter holding last_grant; outputs grant_wr/grant_rd in IDLE.

Test Plan:
- Write burst: vidin_req=1, frame=0, y=3, x=32, mem_ack every cycle -> mem_req rises 1 cycle later with mem_we=1 and mem_addr=0x000C20. Expect exactly 16 vidin_ack. mem_req low the cycle after the 16th ack; state passes through GAP.
- Read burst with stalls: vidout_req=1, frame=1, y=0x3FF, x=0x3F8, mem_ack on alternate cycles, mem_rdata=0xA000+n -> mem_addr=0x1FFFF8, mem_we=0. Expect 8 vidout_ack, each 1 cycle after mem_ack, with vidout_d=0xA000..0xA007 in order.
- Contention: both req held high continuously from reset -> grants RD, WR, RD, WR. Each burst separated by ≥3 cycles after the final ack.
- Reset mid-burst: assert reset after 5 write acks -> next cycle mem_req=0, all outputs at reset values. After release with vidin_req=1, a fresh 16-word burst at the latched address.
- Spurious ack: mem_ack pulsed in IDLE and GAP -> no vidin_ack/vidout_ack, counter unchanged, no state change.
- Base offset/wrap: BASE_ADDR=24'hFFFFF0, frame=0, y=0, x=0x20 -> mem_addr=24'h000010 (modulo wrap).

Source files
------------

// File: rtl/rotate_fb_pkg.sv
// Shared types and helpers for the rotation framebuffer bridge.
package rotate_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_GAP  = 2'd3
    } fb_state_e;

    localparam int unsigned WR_LEN_DEF = 16;
    localparam int unsigned RD_LEN_DEF = 8;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned FB_AW      = 32;

    // Word address of pixel (x, y) in the selected frame; callers truncate to their width.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_AW-1:0] base,
                                                 input logic             frame,
                                                 input logic [9:0]       y,
                                                 input logic [9:0]       x);
        return base + FB_AW'({frame, y, x});
    endfunction

endpackage

// File: rtl/rotate_fb_arb.sv
// Two-client round-robin arbiter; grants are only issued while enabled (bridge idle).
module rotate_fb_arb
    import rotate_fb_pkg::*;
(
    input  logic clk_sys,
    input  logic reset,
    input  logic arb_en,
    input  logic vidin_req,
    input  logic vidout_req,
    output logic grant_wr,
    output logic grant_rd
);

    logic last_wr;

    // On contention the client that was not served last wins.
    assign grant_rd = arb_en & vidout_req & (~vidin_req | last_wr);
    assign grant_wr = arb_en & vidin_req & (~vidout_req | ~last_wr);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_wr <= 1'b1;
        end else if (grant_wr) begin
            last_wr <= 1'b1;
        end else if (grant_rd) begin
            last_wr <= 1'b0;
        end
    end

endmodule

// File: rtl/rotate_fb_bridge.sv
// Arbitrates vidin write bursts and vidout read bursts onto one word-handshaked memory port.
module rotate_fb_bridge
    import rotate_fb_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       WR_LEN    = WR_LEN_DEF,
    parameter int unsigned       RD_LEN    = RD_LEN_DEF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vidin_req,
    input  logic              vidin_frame,
    input  logic [9:0]        vidin_x,
    input  logic [9:0]        vidin_y,
    input  logic [15:0]       vidin_d,
    output logic              vidin_ack,
    input  logic              vidout_req,
    input  logic              vidout_frame,
    input  logic [9:0]        vidout_x,
    input  logic [9:0]        vidout_y,
    output logic [15:0]       vidout_d,
    output logic              vidout_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    fb_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             grant_wr;
    logic             grant_rd;

    rotate_fb_arb u_arb (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .arb_en     (state == ST_IDLE),
        .vidin_req  (vidin_req),
        .vidout_req (vidout_req),
        .grant_wr   (grant_wr),
        .grant_rd   (grant_rd)
    );

    // Write data streams straight through; the client advances on the same-cycle ack.
    assign mem_wdata = vidin_d;
    assign vidin_ack = mem_ack & (state == ST_WR);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            vidout_ack <= 1'b0;
            vidout_d   <= '0;
        end else begin
            vidout_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_wr) begin
                        state    <= ST_WR;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= ADDR_W'(fb_addr(FB_AW'(BASE_ADDR), vidin_frame,
                                                    vidin_y, vidin_x));
                    end else if (grant_rd) begin
                        state    <= ST_RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ADDR_W'(fb_addr(FB_AW'(BASE_ADDR), vidout_frame,
                                                    vidout_y, vidout_x));
                    end
                end
                ST_WR: begin
                    if (mem_ack) begin
                        if (cnt == CNT_W'(WR_LEN - 1)) begin
                            cnt     <= '0;
                            state   <= ST_GAP;
                            mem_req <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (mem_ack) begin
                        vidout_ack <= 1'b1;
                        vidout_d   <= mem_rdata;
                        if (cnt == CNT_W'(RD_LEN - 1)) begin
                            cnt     <= '0;
                            state   <= ST_GAP;
                            mem_req <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                // Clients get a cycle to update req/x/y before requests are sampled again.
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
